button_conditioner: RTL

Front-end input conditioner for the alarm clock. It synchronises and debounces the four raw push-buttons and the alarm-enable switch coming from the board pins. It delivers clean single-cycle press pulses, with optional auto-repeat, to the alarm clock system's button1..button4 inputs, and a debounced level to its alarm1 input. It sits directly upstream of the alarm clock system in the same clock domain.

---
 rtl/button_conditioner.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// button_conditioner
// Input conditioner in front of the alarm clock. Four push-buttons and the
// alarm-enable switch are synchronised and debounced. Each button then drives
// a small press/repeat FSM that produces single-cycle pulses. The alarm
// switch is delivered as a debounced level only. All outputs are registered.

module button_conditioner #(
    parameter int       DEBOUNCE_CYCLES   = 50000,
    parameter int       LONG_PRESS_CYCLES = 25000000,
    parameter int       REPEAT_CYCLES     = 5000000,
    parameter bit [3:0] REPEAT_MASK       = 4'b0011,
    parameter bit       ACTIVE_LOW        = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] raw_btn,
    input  logic       raw_alarm,
    output logic [3:0] btn_pulse,
    output logic [3:0] btn_level,
    output logic [3:0] long_press,
    output logic       alarm_level
);

    // ------------------------------------------------------------------
    // Widths and terminal counts
    // ------------------------------------------------------------------
    localparam int NUM_CH   = 5;   // channels 0..3 = buttons, 4 = alarm
    localparam int ALARM_CH = 4;

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    // One hold counter serves both the long-press and the repeat interval,
    // so it is sized for the larger of the two.
    localparam int HOLD_MAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ?
                              LONG_PRESS_CYCLES : REPEAT_CYCLES;
    localparam int HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_CYCLES - 1);

    // Value the synchronisers hold for "released / off".
    localparam logic [NUM_CH-1:0] IDLE_RAW = {NUM_CH{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        PRESSED  = 2'd1,
        REPEAT   = 2'd2
    } btn_state_t;

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic [NUM_CH-1:0] samp;   // normalised: 1 = pressed / on

    // Two-flop synchroniser for all five asynchronous inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= IDLE_RAW;
            sync2 <= IDLE_RAW;
        end else begin
            // NOTE: sequential state uses <= so every flop samples the
            // pre-edge value of its neighbours; with = the second stage
            // would collapse into the first.
            sync1 <= {raw_alarm, raw_btn};
            sync2 <= sync1;
        end
    end

    assign samp = sync2 ^ IDLE_RAW;

    // ------------------------------------------------------------------
    // Debounce: one stable level and one run-length counter per channel
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] lvl;
    logic [DB_W-1:0]   db_cnt [NUM_CH];

    // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            lvl <= '0;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                db_cnt[ch] <= '0;
            end
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (samp[ch] == lvl[ch]) begin
                    db_cnt[ch] <= '0;
                end else if (db_cnt[ch] == DB_LAST) begin
                    lvl[ch]    <= samp[ch];
                    db_cnt[ch] <= '0;
                end else begin
                    db_cnt[ch] <= db_cnt[ch] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-button press / repeat FSM
    // ------------------------------------------------------------------
    logic [3:0] pulse_nxt;
    logic [3:0] long_nxt;

    for (genvar i = 0; i < 4; i++) begin : g_btn
        btn_state_t        state_q, state_d;
        logic [HOLD_W-1:0] hold_q,  hold_d;
        logic              pulse_d;

        // State and hold counter registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q <= RELEASED;
                hold_q  <= '0;
            end else begin
                state_q <= state_d;
                hold_q  <= hold_d;
            end
        end

        // Next state, hold counter and pulse request.
        always_comb begin
            // NOTE: every variable driven here gets a default first, so no
            // path through the case can leave it unassigned and infer a latch.
            state_d = state_q;
            hold_d  = hold_q;
            pulse_d = 1'b0;

            unique case (state_q)
                RELEASED: begin
                    if (lvl[i]) begin
                        state_d = PRESSED;
                        hold_d  = '0;
                        pulse_d = 1'b1;
                    end
                end

                PRESSED: begin
                    if (!lvl[i]) begin
                        state_d = RELEASED;
                        hold_d  = '0;
                    end else if (REPEAT_MASK[i]) begin
                        if (hold_q == LONG_LAST) begin
                            state_d = REPEAT;
                            hold_d  = '0;
                            pulse_d = 1'b1;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end else if (hold_q != LONG_LAST) begin
                        // Non-repeating button: count up and then sit still.
                        hold_d = hold_q + 1'b1;
                    end
                end

                REPEAT: begin
                    if (!lvl[i]) begin
                        state_d = RELEASED;
                        hold_d  = '0;
                    end else if (hold_q == REP_LAST) begin
                        hold_d  = '0;
                        pulse_d = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end

                default: begin
                    state_d = RELEASED;
                    hold_d  = '0;
                end
            endcase
        end

        assign pulse_nxt[i] = pulse_d;
        assign long_nxt[i]  = (state_d == REPEAT);
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------

    // Register every output so downstream logic sees glitch-free signals.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_pulse   <= '0;
            btn_level   <= '0;
            long_press  <= '0;
            alarm_level <= 1'b0;
        end else begin
            btn_pulse   <= pulse_nxt;
            btn_level   <= lvl[3:0];
            long_press  <= long_nxt;
            alarm_level <= lvl[ALARM_CH];
        end
    end

endmodule
